muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide responder owning the HI/LO registers. EX stage issues
//  MULT/MULTU/DIV/DIVU/MTHI/MTLO requests; this unit accepts them, computes over
//  multiple cycles and returns HI/LO for MFHI/MFLO. busy stalls the pipeline.
// PARAMETERS
//  WIDTH   32  operand width; iteration count = WIDTH; counter is $clog2(WIDTH)+1 bits
// PORTS
//  CLK        in   1        clock, rising edge
//  RST        in   1        asynchronous, active-low reset
//  req_valid  in   1        request present this cycle
//  req_ready  out  1        unit can accept (= state IDLE)
//  req_op     in   3        MD_MULT/MD_MULTU/MD_DIV/MD_DIVU/MD_MTHI/MD_MTLO
//  req_rs     in   WIDTH    rs operand (multiplicand/dividend/MT source)
//  req_rt     in   WIDTH    rt operand (multiplier/divisor)
//  hi, lo     out  WIDTH    architectural HI/LO
//  busy       out  1        multi-cycle op in flight; EX stalls MFHI/MFLO/new mul-div
//  done       out  1        one-cycle pulse: hi/lo just updated by MULT/DIV
// BEHAVIOUR
//  Reset (RST low, any time incl. mid-op): hi=lo=0, state IDLE, busy=0, done=0,
//   req_ready=1; in-flight op discarded, HI/LO never partially written.
//  Accept = req_valid & req_ready on rising edge (edge E0). Invalid req_op: ignored.
//  MTHI/MTLO: hi/lo <= req_rs at E0; no busy, no done; back-to-back allowed.
//  MULT*/DIV*: E0 latch |operands| (signed ops: two's-complement magnitude;
//   unsigned: as-is), record sign flags, enter CALC, busy=1 from E0.
//  CALC: one radix-2 step per edge E1..E32 (WIDTH steps).
//   mul: shift-add into 2*WIDTH accumulator.
//   div: restoring; remainder-minus-divisor via div_step; quotient bit = no-borrow.
//  FIX (E33): sign fixup, write hi/lo, done=1 for cycle E33..E34, busy=0 after E33.
//   mult: {hi,lo}=product, negated if signs differ. div: lo=quotient (negated if
//   signs differ), hi=remainder (sign of dividend).
//  Total: result visible 33 cycles after accept; next request accepted at E33 edge+1.
//  Divide by zero (rt==0): no iteration, FIX at E1: lo=32'hFFFFFFFF, hi=req_rs; done.
//  0x80000000 / -1 (DIV): lo=0x80000000, hi=0 (wraps, no trap).
//  req_valid while busy: not accepted (req_ready=0); requester holds it.
//  hi/lo hold old values throughout CALC; only FIX or MT* writes them.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined: MULT/MULTU complete in FIX at E1 via single-cycle
//   native multiply ({hi,lo} = product, done at E1); DIV path unchanged.
//  Undefined: multiply uses the 32-step shift-add path above.
// STRUCTURE
//  common_param.vh: MD_* op codes (3-bit), state encodings IDLE/CALC/FIX, WIDTH
//   default. EX decode maps R_FORM func to MD_* using these.
//  Sub-module div_step: combinational one-bit restoring step
//   (rem_in, dividend_bit, divisor -> rem_out, q_bit); instantiated once.
//  FSM + counter + 2*WIDTH shift register in muldiv_unit.
// TESTING
//  MULT rs=-3 rt=7 -> busy 33 cycles, done pulse once, {hi,lo}=0xFFFFFFFF_FFFFFFEB.
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  DIV -7/2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU 100/7 -> lo=14, hi=2.
//  DIV rs=5 rt=0 -> done at E1, lo=0xFFFFFFFF, hi=5; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  MTHI 0x1234 then MTLO 0x5678 back-to-back -> hi/lo updated each edge, no busy;
//   req_valid during busy -> req_ready=0, request accepted the cycle after done.
//  RST low at E10 of a DIV -> hi/lo=0, busy=0 immediately; with MULDIV_FAST_MUL_EN,
//   MULT 6*7 -> done at E1, lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM states and defaults for the HI/LO multiply/divide unit.
// Imported by muldiv_unit and div_step.
package muldiv_unit_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_signed(
    input logic [2:0] op
  );
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
// Relies on rem_in < divisor, so the result always fits WIDTH bits.
module div_step
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_in, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0]
                         : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/DIV unit owning HI/LO; MTHI/MTLO write in one edge.
// Define MULDIV_FAST_MUL_EN for a single-cycle native multiply.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_rs,
  input  logic [WIDTH-1:0] req_rt,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e state_q, state_d;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               raw_q, raw_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic op_sgn, op_mul, op_div;
  logic op_mthi, op_mtlo;

  assign op_sgn  = md_is_signed(req_op);
  assign op_mul  = (req_op == MD_MULT) ||
                   (req_op == MD_MULTU);
  assign op_div  = (req_op == MD_DIV) ||
                   (req_op == MD_DIVU);
  assign op_mthi = (req_op == MD_MTHI);
  assign op_mtlo = (req_op == MD_MTLO);

  logic [WIDTH-1:0] abs_rs, abs_rt;

  assign abs_rs = (op_sgn & req_rs[WIDTH-1]) ?
                  -req_rs : req_rs;
  assign abs_rt = (op_sgn & req_rt[WIDTH-1]) ?
                  -req_rt : req_rt;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_rs, ext_rt, fast_prod;

  assign ext_rs = {{WIDTH{op_sgn & req_rs[WIDTH-1]}},
                   req_rs};
  assign ext_rt = {{WIDTH{op_sgn & req_rt[WIDTH-1]}},
                   req_rt};
  assign fast_prod = ext_rs * ext_rt;
`endif

  // Multiply: acc = {partial, multiplier}, shift right.
  logic [WIDTH:0]     mul_add, mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_add  = acc_q[0] ? {1'b0, mcand_q} : '0;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + mul_add;
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}.
  logic [WIDTH-1:0]   rem_out;
  logic               q_bit;
  logic [2*WIDTH-1:0] div_next;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_in      (acc_q[2*WIDTH-1:WIDTH]),
    .dividend_bit(acc_q[WIDTH-1]),
    .divisor     (mcand_q),
    .rem_out     (rem_out),
    .q_bit       (q_bit)
  );

  assign div_next = {rem_out,
                     acc_q[WIDTH-2:0],
                     q_bit};

  logic [WIDTH-1:0]   quo, rem;
  logic [2*WIDTH-1:0] prod_neg;

  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];
  assign prod_neg = -acc_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    raw_d    = raw_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          unique case (1'b1)
            op_mthi: hi_d = req_rs;
            op_mtlo: lo_d = req_rs;
            op_mul: begin
              negq_d = op_sgn &
                       (req_rs[WIDTH-1] ^
                        req_rt[WIDTH-1]);
`ifdef MULDIV_FAST_MUL_EN
              acc_d   = fast_prod;
              raw_d   = 1'b1;
              state_d = FIX;
`else
              acc_d    = {{WIDTH{1'b0}}, abs_rt};
              mcand_d  = abs_rs;
              is_div_d = 1'b0;
              raw_d    = 1'b0;
              cnt_d    = '0;
              state_d  = CALC;
`endif
            end
            op_div: begin
              if (req_rt == '0) begin
                acc_d   = {req_rs, {WIDTH{1'b1}}};
                raw_d   = 1'b1;
                state_d = FIX;
              end else begin
                acc_d    = {{WIDTH{1'b0}}, abs_rs};
                mcand_d  = abs_rt;
                is_div_d = 1'b1;
                raw_d    = 1'b0;
                negq_d   = op_sgn &
                           (req_rs[WIDTH-1] ^
                            req_rt[WIDTH-1]);
                negr_d   = op_sgn & req_rs[WIDTH-1];
                cnt_d    = '0;
                state_d  = CALC;
              end
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1))
          state_d = FIX;
      end
      FIX: begin
        if (raw_q) begin
          {hi_d, lo_d} = acc_q;
        end else if (is_div_q) begin
          lo_d = negq_q ? -quo : quo;
          hi_d = negr_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = negq_q ? prod_neg : acc_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      raw_q    <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      raw_q    <= raw_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign done      = done_q;

endmodule
